// File: rtl/aes_stream_pkg.sv
// Shared types and helpers for the stream arbitration / AES scheduling blocks.
package aes_stream_pkg;

   typedef enum logic [0:0] {
      ARB_IDLE = 1'b0,
      ARB_LOCK = 1'b1
   } arb_state_t;

   // Width of an Avalon-ST empty field; never collapses to zero bits.
   function automatic int empty_width(input int data_width);
      return (data_width > 8) ? $clog2(data_width / 8) : 1;
   endfunction

endpackage

// File: rtl/avalon_st_if.sv
// Avalon-ST packet stream bundle: master drives the beat, slave drives ready.
interface avalon_st_if
   import aes_stream_pkg::*;
#(
   parameter int DATA_WIDTH  = 128,
   parameter int EMPTY_WIDTH = empty_width(DATA_WIDTH)
);
   logic                   valid;
   logic                   ready;
   logic                   sop;
   logic                   eop;
   logic [DATA_WIDTH-1:0]  data;
   logic [EMPTY_WIDTH-1:0] empty;

   modport master (output valid, sop, eop, data, empty, input ready);
   modport slave  (input valid, sop, eop, data, empty, output ready);
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr, wrapping.
// Zero latency; pick is 0 when no request is present (qualify with any).
module rr_pick #(
   parameter int NUM_SRC = 4,
   parameter int PTR_W   = $clog2(NUM_SRC)
) (
   input  logic [NUM_SRC-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
   output logic [PTR_W-1:0]   pick,
   output logic               any
);
   logic [PTR_W-1:0] idx;

   assign any = |req;

   // Walk offsets from far to near so the closest requester to ptr wins.
   always_comb begin
      pick = '0;
      idx  = '0;
      for (int k = NUM_SRC - 1; k >= 0; k--) begin
         idx = PTR_W'((int'(ptr) + k) % NUM_SRC);
         if (req[idx]) pick = idx;
      end
   end
endmodule

// File: rtl/stream_pkt_arbiter.sv
// Packet-atomic round-robin arbiter feeding one header_adder: 1 cycle request to first beat,
// one idle cycle between packets; data_out.ready passes straight back to the granted source only.
module stream_pkt_arbiter
   import aes_stream_pkg::*;
#(
   parameter int NUM_SRC     = 4,
   parameter int DATA_WIDTH  = 128,
   parameter int HEADER_SIZE = 256,
   parameter int EMPTY_WIDTH = empty_width(DATA_WIDTH)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_SRC-1:0]             src_enable,
   input  logic [NUM_SRC*HEADER_SIZE-1:0] hdr_table,
   input  logic [NUM_SRC-1:0]             in_valid,
   output logic [NUM_SRC-1:0]             in_ready,
   input  logic [NUM_SRC-1:0]             in_sop,
   input  logic [NUM_SRC-1:0]             in_eop,
   input  logic [NUM_SRC*DATA_WIDTH-1:0]  in_data,
   input  logic [NUM_SRC*EMPTY_WIDTH-1:0] in_empty,
   avalon_st_if.master                    data_out,
   output logic [HEADER_SIZE-1:0]         header_data,
   output logic [$clog2(NUM_SRC)-1:0]     grant_id,
   output logic                           busy
);
   localparam int SEL_W = $clog2(NUM_SRC);

   arb_state_t       state;
   logic [SEL_W-1:0] rr_ptr;
   logic [SEL_W-1:0] pick;
   logic             any;
   logic [NUM_SRC-1:0] req;
   logic             locked;
   logic             xfer;

   logic [DATA_WIDTH-1:0]  data_arr  [NUM_SRC];
   logic [EMPTY_WIDTH-1:0] empty_arr [NUM_SRC];
   logic [HEADER_SIZE-1:0] hdr_arr   [NUM_SRC];

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
      assign data_arr[i]  = in_data[i*DATA_WIDTH +: DATA_WIDTH];
      assign empty_arr[i] = in_empty[i*EMPTY_WIDTH +: EMPTY_WIDTH];
      assign hdr_arr[i]   = hdr_table[i*HEADER_SIZE +: HEADER_SIZE];
   end

   // Only packet heads compete; a stray mid-packet beat stalls rather than being flushed.
   assign req = in_valid & in_sop & src_enable;

   rr_pick #(
      .NUM_SRC (NUM_SRC),
      .PTR_W   (SEL_W)
   ) u_rr_pick (
      .req  (req),
      .ptr  (rr_ptr),
      .pick (pick),
      .any  (any)
   );

   assign locked = (state == ARB_LOCK);
   assign xfer   = data_out.valid & data_out.ready;

   always_comb begin
      in_ready       = '0;
      data_out.valid = locked & in_valid[grant_id];
      data_out.sop   = locked & in_sop[grant_id];
      data_out.eop   = locked & in_eop[grant_id];
      data_out.data  = data_arr[grant_id];
      data_out.empty = empty_arr[grant_id];
      if (locked) in_ready[grant_id] = data_out.ready;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ARB_IDLE;
         rr_ptr      <= '0;
         grant_id    <= '0;
         header_data <= '0;
         busy        <= 1'b0;
      end else if (state == ARB_IDLE) begin
         if (any) begin
            grant_id    <= pick;
            header_data <= hdr_arr[pick];
            busy        <= 1'b1;
            state       <= ARB_LOCK;
         end
      end else if (xfer && data_out.eop) begin
         state  <= ARB_IDLE;
         busy   <= 1'b0;
         rr_ptr <= (grant_id == SEL_W'(NUM_SRC - 1)) ? '0 : grant_id + 1'b1;
      end
   end
endmodule

// File: tb/tb_stream_pkt_arbiter.sv
// Directed bench for stream_pkt_arbiter: queued per-source packets, a transfer log, inline checks.
module tb_stream_pkt_arbiter;
   typedef struct packed {
      logic [127:0] data;
      logic         sop;
      logic         eop;
      logic [3:0]   empty;
   } beat_t;

   typedef struct {
      logic [1:0]   src;
      logic [127:0] data;
      logic         sop;
      logic         eop;
      logic [3:0]   empty;
      int           stamp;
   } rec_t;

   localparam logic [255:0] HDR1 = {8{32'h48445201}};
   localparam logic [255:0] HDR2 = {8{32'h48445202}};
   localparam logic [255:0] HDR3 = {8{32'h48445203}};

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   src_enable;
   logic [1023:0] hdr_table;
   logic [3:0]   in_valid, in_ready, in_sop, in_eop;
   logic [511:0] in_data;
   logic [15:0]  in_empty;
   logic [255:0] header_data;
   logic [1:0]   grant_id;
   logic         busy;

   avalon_st_if #(.DATA_WIDTH(128), .EMPTY_WIDTH(4)) dout ();

   stream_pkt_arbiter #(
      .NUM_SRC(4), .DATA_WIDTH(128), .HEADER_SIZE(256), .EMPTY_WIDTH(4)
   ) dut (
      .clk(clk), .rst(rst), .src_enable(src_enable), .hdr_table(hdr_table),
      .in_valid(in_valid), .in_ready(in_ready), .in_sop(in_sop), .in_eop(in_eop),
      .in_data(in_data), .in_empty(in_empty), .data_out(dout),
      .header_data(header_data), .grant_id(grant_id), .busy(busy)
   );

   always #5 clk = ~clk;

   logic       rst_ctl, rdy_ctl;
   logic [3:0] en_ctl;
   logic [3:0] pending;
   beat_t      srcq [4][$];
   rec_t       log_q [$];
   int         cyc_n = 0;
   int         total = 0;
   int         bad = 0;

   // One clock: retire last cycle's handshakes, drive new beats at negedge, sample 1ns later.
   task automatic cyc();
      beat_t b;
      rec_t  r;
      @(negedge clk);
      for (int i = 0; i < 4; i++)
         if (pending[i] && srcq[i].size() > 0) srcq[i].delete(0);
      rst = rst_ctl;
      dout.ready = rdy_ctl;
      src_enable = en_ctl;
      in_valid = '0; in_sop = '0; in_eop = '0; in_data = '0; in_empty = '0;
      for (int i = 0; i < 4; i++) begin
         if (srcq[i].size() > 0) begin
            b = srcq[i][0];
            in_valid[i] = 1'b1;
            in_sop[i] = b.sop;
            in_eop[i] = b.eop;
            in_data[i*128 +: 128] = b.data;
            in_empty[i*4 +: 4] = b.empty;
         end
      end
      #1;
      pending = in_valid & in_ready;
      if (dout.valid === 1'b1 && dout.ready === 1'b1) begin
         r.src = grant_id; r.data = dout.data; r.sop = dout.sop;
         r.eop = dout.eop; r.empty = dout.empty; r.stamp = cyc_n;
         log_q.push_back(r);
      end
      cyc_n++;
   endtask

   task automatic push_pkt(input int s, input int n, input logic [127:0] base, input logic [3:0] emp);
      beat_t b;
      for (int k = 0; k < n; k++) begin
         b.data = base + 128'(k);
         b.sop = (k == 0);
         b.eop = (k == n - 1);
         b.empty = (k == n - 1) ? emp : 4'd0;
         srcq[s].push_back(b);
      end
   endtask

   task automatic run_until(input int n, input int budget);
      int c = 0;
      while (log_q.size() < n && c < budget) begin
         cyc();
         c++;
      end
   endtask

   task automatic apply_reset();
      for (int i = 0; i < 4; i++) srcq[i].delete();
      log_q.delete();
      pending = '0;
      rst_ctl = 1'b1; rdy_ctl = 1'b1; en_ctl = 4'hF;
      cyc();
      cyc();
   endtask

   task automatic test_reset();
      apply_reset();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
      total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL reset_grant: got %0d want 0", grant_id); end
      total++; if (header_data !== 256'd0) begin bad++; $display("FAIL reset_header: got %h want 0", header_data); end
      total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL reset_in_ready: got %b want 0000", in_ready); end
      total++; if (dout.valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", dout.valid); end
      rst_ctl = 1'b0;
      cyc();
   endtask

   task automatic test_single();
      logic [127:0] exp_d [3];
      exp_d = '{128'hA0, 128'hA1, 128'hA2};
      log_q.delete();
      push_pkt(2, 3, 128'hA0, 4'd5);
      cyc();
      total++; if ({busy, dout.valid} !== 2'b00) begin bad++; $display("FAIL single_idle: busy/valid got %b want 00", {busy, dout.valid}); end
      cyc();
      total++; if (grant_id !== 2'd2) begin bad++; $display("FAIL single_grant: got %0d want 2", grant_id); end
      total++; if (header_data !== HDR2) begin bad++; $display("FAIL single_header: got %h want %h", header_data, HDR2); end
      total++; if ({busy, dout.valid, dout.sop, dout.data} !== {3'b111, 128'hA0}) begin bad++;
         $display("FAIL single_first_beat: busy/valid/sop/data got %b%b%b %h want 111 a0", busy, dout.valid, dout.sop, dout.data); end
      total++; if (in_ready !== 4'b0100) begin bad++; $display("FAIL single_in_ready: got %b want 0100", in_ready); end
      cyc();
      cyc();
      total++; if ({dout.eop, dout.empty} !== {1'b1, 4'd5}) begin bad++; $display("FAIL single_eop_empty: got %b/%0d want 1/5", dout.eop, dout.empty); end
      cyc();
      total++; if ({busy, dout.valid} !== 2'b00) begin bad++; $display("FAIL single_busy_fall: busy/valid got %b want 00", {busy, dout.valid}); end
      total++; if (log_q.size() !== 3) begin bad++; $display("FAIL single_count: got %0d want 3", log_q.size()); end
      else for (int k = 0; k < 3; k++) begin
         total++; if (log_q[k].data !== exp_d[k]) begin bad++; $display("FAIL single_order[%0d]: got %h want %h", k, log_q[k].data, exp_d[k]); end
      end
   endtask

   task automatic test_wrap_single_beat();
      log_q.delete();
      push_pkt(0, 1, 128'hB0, 4'd0);
      push_pkt(3, 1, 128'hB3, 4'd0);
      cyc();
      cyc();
      total++; if ({grant_id, busy, dout.sop, dout.eop} !== {2'd3, 3'b111}) begin bad++;
         $display("FAIL wrap_first: grant/busy/sop/eop got %0d %b%b%b want 3 111", grant_id, busy, dout.sop, dout.eop); end
      cyc();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL wrap_one_xfer_a: busy got %b want 0", busy); end
      cyc();
      total++; if ({grant_id, busy} !== {2'd0, 1'b1}) begin bad++; $display("FAIL wrap_second: grant/busy got %0d %b want 0 1", grant_id, busy); end
      cyc();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL wrap_one_xfer_b: busy got %b want 0", busy); end
      total++; if (log_q.size() !== 2) begin bad++; $display("FAIL wrap_count: got %0d want 2", log_q.size()); end
      else begin
         total++; if ({log_q[0].src, log_q[1].src} !== {2'd3, 2'd0}) begin bad++;
            $display("FAIL wrap_order: got %0d,%0d want 3,0", log_q[0].src, log_q[1].src); end
         total++; if (log_q[1].stamp - log_q[0].stamp !== 2) begin bad++;
            $display("FAIL wrap_gap: got %0d want 2", log_q[1].stamp - log_q[0].stamp); end
      end
   endtask

   task automatic test_round_robin();
      logic [1:0]   exp_s [8];
      logic [127:0] exp_d [8];
      exp_s = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd3, 2'd3, 2'd0, 2'd0};
      exp_d = '{128'hC000, 128'hC001, 128'hC100, 128'hC101, 128'hC300, 128'hC301, 128'hC010, 128'hC011};
      apply_reset();
      rst_ctl = 1'b0;
      push_pkt(0, 2, 128'hC000, 4'd0);
      push_pkt(0, 2, 128'hC010, 4'd0);
      push_pkt(1, 2, 128'hC100, 4'd0);
      push_pkt(3, 2, 128'hC300, 4'd0);
      run_until(8, 60);
      total++; if (log_q.size() !== 8) begin bad++; $display("FAIL rr_count: got %0d want 8", log_q.size()); end
      else for (int k = 0; k < 8; k++) begin
         total++; if ({log_q[k].src, log_q[k].data} !== {exp_s[k], exp_d[k]}) begin bad++;
            $display("FAIL rr_beat[%0d]: src/data got %0d %h want %0d %h", k, log_q[k].src, log_q[k].data, exp_s[k], exp_d[k]); end
         if (k > 0) begin
            total++; if (log_q[k].stamp - log_q[k-1].stamp !== ((k % 2 == 0) ? 2 : 1)) begin bad++;
               $display("FAIL rr_spacing[%0d]: got %0d want %0d", k, log_q[k].stamp - log_q[k-1].stamp, (k % 2 == 0) ? 2 : 1); end
         end
      end
   endtask

   task automatic test_backpressure();
      logic [127:0] exp_d [8];
      exp_d = '{128'hD0, 128'hD1, 128'hD2, 128'hD3, 128'hD4, 128'hD5, 128'hE0, 128'hE1};
      log_q.delete();
      push_pkt(1, 6, 128'hD0, 4'd0);
      push_pkt(2, 2, 128'hE0, 4'd0);
      cyc();
      cyc();
      total++; if (in_ready !== 4'b0010) begin bad++; $display("FAIL bp_ready_on: got %b want 0010", in_ready); end
      cyc();
      rdy_ctl = 1'b0;
      for (int k = 0; k < 4; k++) begin
         cyc();
         total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL bp_ready_off[%0d]: got %b want 0000", k, in_ready); end
         total++; if ({dout.valid, dout.data} !== {1'b1, 128'hD2}) begin bad++;
            $display("FAIL bp_hold[%0d]: valid/data got %b %h want 1 d2", k, dout.valid, dout.data); end
      end
      rdy_ctl = 1'b1;
      run_until(8, 40);
      total++; if (log_q.size() !== 8) begin bad++; $display("FAIL bp_count: got %0d want 8", log_q.size()); end
      else for (int k = 0; k < 8; k++) begin
         total++; if (log_q[k].data !== exp_d[k]) begin bad++; $display("FAIL bp_beat[%0d]: got %h want %h", k, log_q[k].data, exp_d[k]); end
      end
   endtask

   task automatic test_mask();
      logic [1:0] exp_s [6];
      exp_s = '{2'd3, 2'd3, 2'd0, 2'd0, 2'd1, 2'd1};
      log_q.delete();
      en_ctl = 4'b1011;
      push_pkt(0, 2, 128'h100, 4'd0);
      push_pkt(1, 2, 128'h110, 4'd0);
      push_pkt(2, 3, 128'h120, 4'd0);
      push_pkt(3, 2, 128'h130, 4'd0);
      run_until(6, 40);
      for (int k = 0; k < 5; k++) cyc();
      total++; if (log_q.size() !== 6) begin bad++; $display("FAIL mask_count: got %0d want 6", log_q.size()); end
      else for (int k = 0; k < 6; k++) begin
         total++; if (log_q[k].src !== exp_s[k]) begin bad++; $display("FAIL mask_order[%0d]: got %0d want %0d", k, log_q[k].src, exp_s[k]); end
      end
      total++; if ({busy, in_ready} !== 5'b0) begin bad++; $display("FAIL mask_idle: busy/in_ready got %b %b want 0 0000", busy, in_ready); end
      en_ctl = 4'hF;
      cyc();
      cyc();
      total++; if ({grant_id, busy} !== {2'd2, 1'b1}) begin bad++; $display("FAIL mask_grant2: grant/busy got %0d %b want 2 1", grant_id, busy); end
      en_ctl = 4'b1011;
      run_until(9, 20);
      cyc();
      total++; if (log_q.size() !== 9) begin bad++; $display("FAIL mask_mid_count: got %0d want 9", log_q.size()); end
      else begin
         total++; if ({log_q[6].data, log_q[7].data, log_q[8].data, log_q[8].eop} !== {128'h120, 128'h121, 128'h122, 1'b1}) begin bad++;
            $display("FAIL mask_mid_pkt: got %h %h %h eop=%b want 120 121 122 eop=1", log_q[6].data, log_q[7].data, log_q[8].data, log_q[8].eop); end
      end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL mask_done: busy got %b want 0", busy); end
   endtask

   task automatic test_reset_mid_packet();
      log_q.delete();
      push_pkt(3, 4, 128'h200, 4'd0);
      push_pkt(1, 2, 128'h210, 4'd0);
      cyc();
      cyc();
      total++; if ({grant_id, header_data} !== {2'd3, HDR3}) begin bad++;
         $display("FAIL rstmid_grant3: got %0d %h want 3 %h", grant_id, header_data, HDR3); end
      rst_ctl = 1'b1;
      cyc();
      rst_ctl = 1'b0;
      srcq[3].delete();
      pending[3] = 1'b0;
      log_q.delete();
      cyc();
      total++; if ({busy, in_ready, dout.valid} !== 6'b0) begin bad++;
         $display("FAIL rstmid_quiet: busy/in_ready/valid got %b %b %b want 0 0000 0", busy, in_ready, dout.valid); end
      total++; if (header_data !== 256'd0) begin bad++; $display("FAIL rstmid_header: got %h want 0", header_data); end
      cyc();
      total++; if ({grant_id, busy, header_data} !== {2'd1, 1'b1, HDR1}) begin bad++;
         $display("FAIL rstmid_regrant: grant/busy got %0d %b header %h want 1 1 %h", grant_id, busy, header_data, HDR1); end
      run_until(2, 10);
      total++; if (log_q.size() !== 2) begin bad++; $display("FAIL rstmid_count: got %0d want 2", log_q.size()); end
      else begin
         total++; if ({log_q[0].data, log_q[1].data} !== {128'h210, 128'h211}) begin bad++;
            $display("FAIL rstmid_beats: got %h %h want 210 211", log_q[0].data, log_q[1].data); end
      end
   endtask

   initial begin
      for (int i = 0; i < 4; i++) hdr_table[i*256 +: 256] = {8{32'h48445200 + i}};
      rst = 1'b1; dout.ready = 1'b1; src_enable = 4'hF;
      in_valid = '0; in_sop = '0; in_eop = '0; in_data = '0; in_empty = '0;
      pending = '0; rst_ctl = 1'b1; rdy_ctl = 1'b1; en_ctl = 4'hF;
      test_reset();
      test_single();
      test_wrap_single_beat();
      test_round_robin();
      test_backpressure();
      test_mask();
      test_reset_mid_packet();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/stream_pkt_arbiter.md
Name: stream_pkt_arbiter

Overview:
- Packet-atomic round-robin arbiter that shares one header_adder instance among NUM_SRC Avalon-ST packet sources.
- Grants one source at a time and forwards its packet unchanged to data_out.
- Drives header_data from a per-source header table, held stable for the whole granted packet.
- Sits directly upstream of header_adder: data_out feeds header_adder.data_in, header_data feeds header_adder.header_data.

Parameters:
- NUM_SRC, 4, number of requesting sources (2..16).
- DATA_WIDTH, 128, stream data width in bits (multiple of 8).
- HEADER_SIZE, 256, per-source header width in bits.
- EMPTY_WIDTH, $clog2(DATA_WIDTH/8), width of the empty field.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- src_enable  in  NUM_SRC  per-source arbitration mask, sampled only at arbitration.
- hdr_table  in  NUM_SRC*HEADER_SIZE  header for source i at bits [i*HEADER_SIZE +: HEADER_SIZE].
- in_valid  in  NUM_SRC  per-source valid.
- in_ready  out  NUM_SRC  per-source ready.
- in_sop  in  NUM_SRC  per-source start of packet.
- in_eop  in  NUM_SRC  per-source end of packet.
- in_data  in  NUM_SRC*DATA_WIDTH  per-source data, packed like hdr_table.
- in_empty  in  NUM_SRC*EMPTY_WIDTH  per-source empty.
- data_out  avalon_st_if.master  -  muxed packet stream to header_adder.
- header_data  out  HEADER_SIZE  header of the granted source, registered.
- grant_id  out  $clog2(NUM_SRC)  current or last granted source.
- busy  out  1  high while a packet is locked.

Behaviour:
- Reset values: state IDLE, rr_ptr=0, grant_id=0, header_data=0, busy=0, in_ready=0, data_out.valid=0.
- Reset asserted mid-packet drops the lock immediately. The remaining beats of that packet are not forwarded; upstream re-sends.

IDLE state:
- Candidate set: req[i] = in_valid[i] & in_sop[i] & src_enable[i].
- If req is nonzero, pick the first set bit searching upward from rr_ptr, wrapping modulo NUM_SRC.
- Registered on the same edge: grant_id = pick, header_data = hdr_table slice of pick, busy = 1, state -> LOCK.
- Outputs are all quiet in IDLE: data_out.valid=0, in_ready=0.
- A valid beat without sop is never a candidate. It stays stalled; no flush.

LOCK state (g = grant_id):
- data_out.valid/sop/eop/data/empty = in_*[g], combinational pass-through.
- in_ready[g] = data_out.ready; every other in_ready = 0.
- A transfer is data_out.valid & data_out.ready.
- On a transfer with eop: state -> IDLE, busy=0, rr_ptr = (g+1) mod NUM_SRC.
- header_data and grant_id do not change until the next grant.
- src_enable changes during LOCK do not abort the packet.

Latency and throughput:
- Request to first forwarded beat: 1 cycle.
- One idle cycle between packets, which gives header_adder's idle detection a clean sop.

Boundary conditions:
- Single-beat packet (sop & eop on the same beat) completes LOCK in 1 transfer.
- When all requesters are masked, the block stays IDLE.
- Wrap: rr_ptr=NUM_SRC-1 with req on sources 0 and NUM_SRC-1 picks NUM_SRC-1, then 0.
- Backpressure: data_out.ready=0 holds the beat; in_ready[g]=0.

Decomposition:
- Package aes_stream_pkg holds:
  - state enum arb_state_t {ARB_IDLE, ARB_LOCK};
  - localparam function for EMPTY_WIDTH.
- Sub-module rr_pick: combinational round-robin priority picker.
  - Inputs: req[NUM_SRC], ptr.
  - Outputs: pick, any.
  - Reused by later multi-channel AES schedulers.

Test Plan (NUM_SRC=4, DATA_WIDTH=128, HEADER_SIZE=256, data_out.ready=1 unless stated):
- Single source: src 2 sends a 3-beat packet, data 0xA0..0xA2, empty=5 on eop -> grant_id=2; header_data=hdr_table[2] one cycle after request; 3 beats out in order; eop empty=5; busy falls after beat 3; rr_ptr=3.
- Round robin: sources 0,1,3 hold 2-beat packets simultaneously from reset -> output order 0,1,3, then 0 again if re-requested; one idle cycle between packets.
- Backpressure: drop data_out.ready for 4 cycles mid-packet -> in_ready[g]=0; beat held stable; no other in_ready asserted; no beat lost or duplicated.
- Mask: src_enable=4'b1011 with all four requesting -> source 2 never granted. Clear the mask bit of the active source mid-packet -> its packet completes intact.
- Wrap and single beat: rr_ptr=3, requests on 0 and 3 with 1-beat (sop & eop) packets -> grant 3 then 0; each packet LOCKs for exactly one transfer.
- Reset mid-packet: assert rst on beat 2 of 4 -> next cycle busy=0, in_ready=0, header_data=0. After release, src 1 requesting is granted first (rr_ptr=0, lowest requester).
